// File: rtl/hazard_pipe_ctrl.sv
// E/M/W control pipeline with load-use stall, branch/jump flush, E-stage forwarding
// selects and saturating stall/flush event counters.
module hazard_pipe_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              RegWriteD,
  input  logic              MemtoRegD,
  input  logic              MemWriteD,
  input  logic              BranchD,
  input  logic              ALUSrcD,
  input  logic              RegDstD,
  input  logic              JumpD,
  input  logic [2:0]        ALUControlD,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RdD,
  input  logic              ZeroM,
  input  logic              cnt_clr,
  output logic              RegWriteE,
  output logic              RegWriteM,
  output logic              RegWriteW,
  output logic              MemtoRegE,
  output logic              MemtoRegM,
  output logic              MemtoRegW,
  output logic              MemWriteE,
  output logic              MemWriteM,
  output logic              BranchE,
  output logic              BranchM,
  output logic              ALUSrcE,
  output logic              RegDstE,
  output logic [2:0]        ALUControlE,
  output logic [REG_AW-1:0] RsE,
  output logic [REG_AW-1:0] RtE,
  output logic [REG_AW-1:0] WriteRegE,
  output logic [REG_AW-1:0] WriteRegM,
  output logic [REG_AW-1:0] WriteRegW,
  output logic              PCSrcM,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [REG_AW-1:0] RdE;
  logic lwstall, stall_eff, jump_eff, bubble_e;

  assign WriteRegE = RegDstE ? RdE : RtE;
  assign PCSrcM    = BranchM & ZeroM;
  assign lwstall   = MemtoRegE & RegWriteE & ((RtE == RsD) | (RtE == RtD));
  // A taken branch squashes the stalled instruction anyway, so it wins over the stall.
  assign stall_eff = lwstall & ~PCSrcM;
  assign jump_eff  = JumpD & ~lwstall & ~PCSrcM;
  assign StallF    = stall_eff;
  assign StallD    = stall_eff;
  assign FlushD    = PCSrcM | jump_eff;
  assign bubble_e  = PCSrcM | lwstall;

  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (WriteRegM != '0) && (WriteRegM == RsE))
      ForwardAE = 2'b10;
    else if (RegWriteW && (WriteRegW != '0) && (WriteRegW == RsE))
      ForwardAE = 2'b01;
  end

  always_comb begin
    ForwardBE = 2'b00;
    if (RegWriteM && (WriteRegM != '0) && (WriteRegM == RtE))
      ForwardBE = 2'b10;
    else if (RegWriteW && (WriteRegW != '0) && (WriteRegW == RtE))
      ForwardBE = 2'b01;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || bubble_e) begin
      RegWriteE   <= 1'b0;
      MemtoRegE   <= 1'b0;
      MemWriteE   <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      RegDstE     <= 1'b0;
      ALUControlE <= 3'b000;
      RsE         <= '0;
      RtE         <= '0;
      RdE         <= '0;
    end else begin
      RegWriteE   <= RegWriteD;
      MemtoRegE   <= MemtoRegD;
      MemWriteE   <= MemWriteD;
      BranchE     <= BranchD;
      ALUSrcE     <= ALUSrcD;
      RegDstE     <= RegDstD;
      ALUControlE <= ALUControlD;
      RsE         <= RsD;
      RtE         <= RtD;
      RdE         <= RdD;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || PCSrcM) begin
      RegWriteM <= 1'b0;
      MemtoRegM <= 1'b0;
      MemWriteM <= 1'b0;
      BranchM   <= 1'b0;
      WriteRegM <= '0;
    end else begin
      RegWriteM <= RegWriteE;
      MemtoRegM <= MemtoRegE;
      MemWriteM <= MemWriteE;
      BranchM   <= BranchE;
      WriteRegM <= WriteRegE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      WriteRegW <= '0;
    end else begin
      RegWriteW <= RegWriteM;
      MemtoRegW <= MemtoRegM;
      WriteRegW <= WriteRegM;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_eff && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (FlushD && (flush_cnt != '1))    flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Bench for hazard_pipe_ctrl: scoreboarded control stream plus directed hazard,
// forwarding, flush, reset and counter-saturation scenarios (counters 2 bits wide).
module tb_hazard_pipe_ctrl;
  localparam int AW = 5;
  localparam int CW = 2;

  logic clk, reset_n;
  logic RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, RegDstD, JumpD;
  logic [2:0] ALUControlD;
  logic [AW-1:0] RsD, RtD, RdD;
  logic ZeroM, cnt_clr;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemtoRegW;
  logic MemWriteE, MemWriteM, BranchE, BranchM, ALUSrcE, RegDstE;
  logic [2:0] ALUControlE;
  logic [AW-1:0] RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic PCSrcM, StallF, StallD, FlushD;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CW-1:0] stall_cnt, flush_cnt;

  typedef struct packed {
    logic          rw;
    logic [AW-1:0] wr;
  } exp_t;
  exp_t sb_q[$];

  int n_chk = 0;
  int n_pass = 0;

  hazard_pipe_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .BranchD(BranchD), .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .JumpD(JumpD),
    .ALUControlD(ALUControlD), .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .ZeroM(ZeroM), .cnt_clr(cnt_clr),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .MemtoRegW(MemtoRegW),
    .MemWriteE(MemWriteE), .MemWriteM(MemWriteM), .BranchE(BranchE), .BranchM(BranchM),
    .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
    .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .PCSrcM(PCSrcM), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input logic rw, mtr, mw, br, src, dst, jmp,
                       input logic [2:0] alu, input logic [AW-1:0] rs, rt, rd);
    RegWriteD = rw; MemtoRegD = mtr; MemWriteD = mw; BranchD = br;
    ALUSrcD = src; RegDstD = dst; JumpD = jmp; ALUControlD = alu;
    RsD = rs; RtD = rt; RdD = rd;
  endtask

  task automatic bubble();
    drive(0, 0, 0, 0, 0, 0, 0, 3'b000, '0, '0, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // a writes wra, b writes wrb, c reads rsc/rtc; afterwards c is in E, b in M, a in W
  task automatic fwd_seq(input logic rwa, input logic [AW-1:0] wra,
                         input logic rwb, input logic [AW-1:0] wrb,
                         input logic [AW-1:0] rsc, input logic [AW-1:0] rtc);
    drive(rwa, 0, 0, 0, 0, 1, 0, 3'b010, '0, '0, wra); step();
    drive(rwb, 0, 0, 0, 0, 1, 0, 3'b010, '0, '0, wrb); step();
    drive(0, 0, 0, 0, 0, 0, 0, 3'b010, rsc, rtc, '0);  step();
  endtask

  initial begin
    logic rw, dst, mw, src;
    logic [2:0] alu;
    logic [AW-1:0] rs, rt, rd;
    exp_t e;

    reset_n = 1'b0; cnt_clr = 1'b0; ZeroM = 1'b0;
    bubble();
    #12;
    chk("rst_regwrite_e", RegWriteE, 0);
    chk("rst_regwrite_w", RegWriteW, 0);
    chk("rst_writereg_m", WriteRegM, 0);
    chk("rst_fwd_a", ForwardAE, 0);
    chk("rst_pcsrc", PCSrcM, 0);
    chk("rst_stallf", StallF, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    reset_n = 1'b1;
    step();

    // hazard-free stream: E after 1 cycle, W after 3 cycles
    for (int i = 0; i < 23; i++) begin
      if (i < 20) begin
        rw = 1'($urandom_range(0, 1)); dst = 1'($urandom_range(0, 1));
        mw = 1'($urandom_range(0, 1)); src = 1'($urandom_range(0, 1));
        alu = 3'($urandom_range(0, 7));
        rs = AW'($urandom_range(0, 31)); rt = AW'($urandom_range(0, 31));
        rd = AW'($urandom_range(0, 31));
      end else begin
        rw = 0; dst = 0; mw = 0; src = 0; alu = 0; rs = 0; rt = 0; rd = 0;
      end
      drive(rw, 0, mw, 0, src, dst, 0, alu, rs, rt, rd);
      e.rw = rw;
      e.wr = dst ? rd : rt;
      sb_q.push_back(e);
      step();
      chk("stream_alu_e", ALUControlE, alu);
      chk("stream_wr_e", WriteRegE, e.wr);
      if (sb_q.size() == 3) begin
        e = sb_q.pop_front();
        chk("stream_rw_w", RegWriteW, e.rw);
        chk("stream_wr_w", WriteRegW, e.wr);
      end
    end

    fwd_seq(1, 3, 1, 3, 3, 0);
    chk("fwd_a_m", ForwardAE, 2'b10);
    chk("fwd_b_none", ForwardBE, 2'b00);
    fwd_seq(1, 3, 0, 3, 3, 0);
    chk("fwd_a_w", ForwardAE, 2'b01);
    fwd_seq(1, 0, 0, 3, 3, 0);
    chk("fwd_a_w_r0", ForwardAE, 2'b00);
    fwd_seq(1, 0, 1, 0, 0, 0);
    chk("fwd_a_m_r0", ForwardAE, 2'b00);
    fwd_seq(1, 7, 1, 7, 0, 7);
    chk("fwd_b_m", ForwardBE, 2'b10);
    fwd_seq(1, 7, 0, 0, 0, 7);
    chk("fwd_b_w", ForwardBE, 2'b01);
    fwd_seq(1, 4, 1, 5, 4, 5);
    chk("fwd_a_split", ForwardAE, 2'b01);
    chk("fwd_b_split", ForwardBE, 2'b10);

    // load-use stall
    bubble(); repeat (3) step();
    drive(1, 1, 0, 0, 1, 0, 0, 3'b010, 0, 2, 0); step();
    drive(1, 0, 0, 0, 0, 1, 0, 3'b010, 2, 3, 4); #1;
    chk("lw_stallf", StallF, 1);
    chk("lw_stalld", StallD, 1);
    chk("lw_flushd", FlushD, 0);
    step();
    chk("lw_bub_rw_e", RegWriteE, 0);
    chk("lw_bub_mtr_e", MemtoRegE, 0);
    chk("lw_bub_rt_e", RtE, 0);
    chk("lw_m_rw", RegWriteM, 1);
    chk("lw_m_wr", WriteRegM, 2);
    chk("lw_stall_cnt", stall_cnt, 1);
    #1;
    chk("lw_stallf_clr", StallF, 0);

    // five more load-use stalls saturate the 2-bit counter
    drive(1, 1, 0, 0, 1, 0, 0, 3'b010, 2, 2, 0);
    repeat (10) step();
    chk("sat_stall_cnt", stall_cnt, 3);
    chk("sat_rw_m", RegWriteM, 1);

    // asynchronous reset mid-stream
    #1; reset_n = 1'b0; #1;
    chk("arst_rw_m", RegWriteM, 0);
    chk("arst_wr_m", WriteRegM, 0);
    chk("arst_stall_cnt", stall_cnt, 0);
    chk("arst_mtr_w", MemtoRegW, 0);
    #2; reset_n = 1'b1;
    step(); step(); step();
    chk("clr_pre_cnt", stall_cnt, 1);
    chk("clr_pre_stall", StallF, 1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_stall_cnt", stall_cnt, 0);

    // taken branch in M
    bubble(); repeat (3) step();
    drive(0, 0, 0, 1, 0, 0, 0, 3'b110, 1, 6, 0); step();
    drive(1, 0, 0, 0, 0, 1, 0, 3'b010, 1, 2, 4); step();
    drive(1, 0, 0, 0, 0, 1, 0, 3'b010, 1, 2, 5);
    ZeroM = 1'b1; #1;
    chk("br_pcsrc", PCSrcM, 1);
    chk("br_flushd", FlushD, 1);
    chk("br_stallf", StallF, 0);
    step();
    ZeroM = 1'b0;
    chk("br_rw_e", RegWriteE, 0);
    chk("br_rw_m", RegWriteM, 0);
    chk("br_branch_m", BranchM, 0);
    chk("br_wr_w", WriteRegW, 6);
    chk("br_flush_cnt", flush_cnt, 1);

    // branch and load-use in the same cycle
    drive(0, 0, 0, 1, 0, 0, 0, 3'b110, 1, 6, 0); step();
    drive(1, 1, 0, 0, 1, 0, 0, 3'b010, 0, 2, 0); step();
    drive(1, 0, 0, 0, 0, 1, 0, 3'b010, 2, 3, 4);
    ZeroM = 1'b1; #1;
    chk("brlw_pcsrc", PCSrcM, 1);
    chk("brlw_stallf", StallF, 0);
    chk("brlw_stalld", StallD, 0);
    chk("brlw_flushd", FlushD, 1);
    step();
    ZeroM = 1'b0;
    chk("brlw_stall_cnt", stall_cnt, 0);
    chk("brlw_flush_cnt", flush_cnt, 2);
    chk("brlw_rw_m", RegWriteM, 0);
    chk("brlw_mtr_m", MemtoRegM, 0);

    // jumps, alone and suppressed by a load-use stall
    cnt_clr = 1'b1; bubble(); step(); cnt_clr = 1'b0;
    repeat (2) step();
    drive(0, 0, 0, 0, 0, 0, 1, 3'b101, 0, 0, 0); #1;
    chk("j_flushd", FlushD, 1);
    chk("j_stallf", StallF, 0);
    step();
    chk("j_alu_e", ALUControlE, 3'b101);
    chk("j_flush_cnt", flush_cnt, 1);
    drive(1, 1, 0, 0, 1, 0, 0, 3'b010, 0, 2, 0); step();
    drive(0, 0, 0, 0, 0, 0, 1, 3'b101, 2, 0, 0); #1;
    chk("jlw_flushd", FlushD, 0);
    chk("jlw_stallf", StallF, 1);
    step();
    chk("jlw_flush_cnt", flush_cnt, 1);
    chk("jlw_stall_cnt", stall_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
